// File: rtl/guitar_pkg.sv
// Shared constants, state type and lane geometry helper for the fretboard lane renderer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package guitar_pkg;

    // USB HID keycodes for the control keys.
    localparam logic [7:0] KC_PAUSE  = 8'h2C;
    localparam logic [7:0] KC_FASTER = 8'h52;
    localparam logic [7:0] KC_SLOWER = 8'h51;

    // Default lane keys, lane 0 in the most significant byte (A, S, D, F, G).
    localparam logic [39:0] DEFAULT_LANE_KEYS = {8'h04, 8'h16, 8'h07, 8'h09, 8'h0A};

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } state_e;

    // Lane centres split the screen into NUM_LANES+1 equal gaps.
    function automatic logic [9:0] lane_pos(input int screen_w, input int num_lanes,
                                            input int lane);
        int pos;
        pos = (screen_w * (lane + 1)) / (num_lanes + 1);
        return 10'(pos);
    endfunction

endpackage

// File: rtl/lane_hold.sv
// Per-lane highlight: lit while the lane key is down, then held for HOLD_FRAMES frames.
// Latency: one frame from keycode to hit_o.
// Backpressure: none; evaluates every frame.
//
// Ports: frame_clk_i (frame clock), rst_ni (async active-low reset),
//        keycode_i (current USB keycode), hit_o (registered highlight flag).
module lane_hold #(
    parameter int         HOLD_FRAMES = 4,
    parameter logic [7:0] KEY         = 8'h04
) (
    input  logic       frame_clk_i,
    input  logic       rst_ni,
    input  logic [7:0] keycode_i,
    output logic       hit_o
);

    logic       key_present;
    logic [3:0] cnt_q, cnt_d;
    logic       hit_q, hit_d;

    assign key_present = (keycode_i == KEY);

    // The flag looks at the counter before it decrements, so a release
    // yields exactly HOLD_FRAMES extra lit frames.
    always_comb begin
        cnt_d = cnt_q;
        hit_d = key_present | (cnt_q != 4'd0);
        if (key_present) begin
            cnt_d = 4'(HOLD_FRAMES);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge frame_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
            hit_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hit_q <= hit_d;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/fretboard_lanes.sv
// Fretboard renderer control: lane geometry, scrolling fret offset, speed/pause keys, lane highlights.
// Latency: one frame from keycode to every registered output; lane_x/lane_s are constants.
// Backpressure: none; one update per frame_clk edge.
//
// Ports: frame_clk (frame clock), Reset_n (async active-low reset), keycode (USB keycode, 0 = none),
//        lane_x (packed lane centres, lane i at [10i+9:10i]), lane_s (lane half-width),
//        fret_y (fret pattern offset), lane_hit (per-lane highlight), speed (scroll step), paused.
module fretboard_lanes
    import guitar_pkg::*;
#(
    parameter int                     NUM_LANES    = 5,
    parameter int                     SCREEN_W     = 640,
    parameter int                     LANE_HALF_W  = 5,
    parameter int                     FRET_SPACING = 60,
    parameter int                     SPEED_MAX    = 7,
    parameter int                     HOLD_FRAMES  = 4,
    parameter logic [NUM_LANES*8-1:0] LANE_KEYS    = DEFAULT_LANE_KEYS,
    parameter logic [7:0]             KEY_PAUSE    = KC_PAUSE,
    parameter logic [7:0]             KEY_FASTER   = KC_FASTER,
    parameter logic [7:0]             KEY_SLOWER   = KC_SLOWER
) (
    input  logic                    frame_clk,
    input  logic                    Reset_n,
    input  logic [7:0]              keycode,
    output logic [NUM_LANES*10-1:0] lane_x,
    output logic [9:0]              lane_s,
    output logic [9:0]              fret_y,
    output logic [NUM_LANES-1:0]    lane_hit,
    output logic [3:0]              speed,
    output logic                    paused
);

    localparam logic [3:0]  SPEED_TOP = 4'(SPEED_MAX);
    localparam logic [10:0] SPACING   = 11'(FRET_SPACING);

    state_e      state_q;
    logic        paused_q;
    logic [9:0]  fret_y_q, fret_y_d;
    logic [3:0]  speed_q, speed_d;
    logic [10:0] fret_sum;

    // Edge-detect history: one bit per control key, plus an arm flag so a key
    // held through reset release is recorded as history rather than seen as a press.
    logic pause_hist_q, faster_hist_q, slower_hist_q, armed_q;
    logic pause_hit, faster_hit, slower_hit;
    logic pause_edge, faster_edge, slower_edge;

    assign pause_hit   = (keycode == KEY_PAUSE);
    assign faster_hit  = (keycode == KEY_FASTER);
    assign slower_hit  = (keycode == KEY_SLOWER);
    assign pause_edge  = armed_q & pause_hit  & ~pause_hist_q;
    assign faster_edge = armed_q & faster_hit & ~faster_hist_q;
    assign slower_edge = armed_q & slower_hit & ~slower_hist_q;

    // Sum in 11 bits so the wrap is taken before any overflow.
    always_comb begin
        fret_sum = {1'b0, fret_y_q} + {7'd0, speed_q};
        fret_y_d = fret_y_q;
        if (state_q == RUN) begin
            fret_y_d = 10'(fret_sum % SPACING);
        end
    end

    always_comb begin
        speed_d = speed_q;
        if (faster_edge && (speed_q < SPEED_TOP)) begin
            speed_d = speed_q + 4'd1;
        end else if (slower_edge && (speed_q != 4'd0)) begin
            speed_d = speed_q - 4'd1;
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= RUN;
            paused_q      <= 1'b0;
            fret_y_q      <= 10'd0;
            speed_q       <= 4'd1;
            pause_hist_q  <= 1'b0;
            faster_hist_q <= 1'b0;
            slower_hist_q <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            fret_y_q      <= fret_y_d;
            speed_q       <= speed_d;
            pause_hist_q  <= pause_hit;
            faster_hist_q <= faster_hit;
            slower_hist_q <= slower_hit;
            armed_q       <= 1'b1;
            case (state_q)
                RUN: begin
                    if (pause_edge) begin
                        state_q  <= PAUSED;
                        paused_q <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (pause_edge) begin
                        state_q  <= RUN;
                        paused_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    paused_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_hold #(
            .HOLD_FRAMES (HOLD_FRAMES),
            .KEY         (LANE_KEYS[(NUM_LANES-1-i)*8 +: 8])
        ) u_lane_hold (
            .frame_clk_i (frame_clk),
            .rst_ni      (Reset_n),
            .keycode_i   (keycode),
            .hit_o       (lane_hit[i])
        );

        assign lane_x[10*i +: 10] = lane_pos(SCREEN_W, NUM_LANES, i);
    end

    assign lane_s = 10'(LANE_HALF_W);
    assign fret_y = fret_y_q;
    assign speed  = speed_q;
    assign paused = paused_q;

endmodule

// File: tb/tb_fretboard_lanes.sv
// Self-checking bench for fretboard_lanes: directed scenarios then randomized keycodes vs a frame-level model.
// Latency: checks sample 1 time unit after each frame edge.
// Backpressure: n/a.
module tb_fretboard_lanes;

    localparam int NL       = 5;
    localparam int SPACING  = 60;
    localparam int SPD_MAX  = 7;
    localparam int HOLD     = 4;
    localparam logic [7:0] K_PAUSE = 8'h2C;
    localparam logic [7:0] K_FAST  = 8'h52;
    localparam logic [7:0] K_SLOW  = 8'h51;
    localparam logic [7:0] LANE_KEY [NL] = '{8'h04, 8'h16, 8'h07, 8'h09, 8'h0A};
    localparam int         EXP_X    [NL] = '{106, 213, 320, 426, 533};

    logic            frame_clk = 1'b0;
    logic            Reset_n   = 1'b1;
    logic [7:0]      keycode   = 8'h00;
    logic [NL*10-1:0] lane_x;
    logic [9:0]      lane_s;
    logic [9:0]      fret_y;
    logic [NL-1:0]   lane_hit;
    logic [3:0]      speed;
    logic            paused;

    int checks = 0;
    int errors = 0;

    // Frame-level model state.
    bit         m_paused;
    int         m_speed;
    int         m_fret;
    int         m_frame;
    int         m_last [NL];
    bit         m_armed;
    logic [7:0] m_prev;

    always #5 frame_clk = ~frame_clk;

    fretboard_lanes dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .lane_x    (lane_x),
        .lane_s    (lane_s),
        .fret_y    (fret_y),
        .lane_hit  (lane_hit),
        .speed     (speed),
        .paused    (paused)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_paused = 1'b0;
        m_speed  = 1;
        m_fret   = 0;
        m_frame  = 0;
        for (int i = 0; i < NL; i++) m_last[i] = -100;
        m_armed  = 1'b0;
        m_prev   = 8'h00;
    endfunction

    // One frame: fret scroll uses the pre-edge pause state and speed.
    function automatic void model_step(input logic [7:0] k);
        bit p_edge, f_edge, s_edge;
        p_edge = m_armed && (k == K_PAUSE) && (m_prev != K_PAUSE);
        f_edge = m_armed && (k == K_FAST)  && (m_prev != K_FAST);
        s_edge = m_armed && (k == K_SLOW)  && (m_prev != K_SLOW);
        if (!m_paused) m_fret = (m_fret + m_speed) % SPACING;
        if (p_edge) m_paused = !m_paused;
        if (f_edge && m_speed < SPD_MAX) m_speed++;
        if (s_edge && m_speed > 0) m_speed--;
        m_frame++;
        for (int i = 0; i < NL; i++) if (k == LANE_KEY[i]) m_last[i] = m_frame;
        m_prev  = k;
        m_armed = 1'b1;
    endfunction

    // A lane is lit if its key was present on any of the last HOLD+1 frames.
    function automatic logic [NL-1:0] exp_hit();
        logic [NL-1:0] v;
        for (int i = 0; i < NL; i++) v[i] = ((m_frame - m_last[i]) <= HOLD);
        return v;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".fret_y"},   32'(fret_y),   32'(m_fret));
        check({tag, ".speed"},    32'(speed),    32'(m_speed));
        check({tag, ".paused"},   32'(paused),   32'(m_paused));
        check({tag, ".lane_hit"}, 32'(lane_hit), 32'(exp_hit()));
        check({tag, ".lane_s"},   32'(lane_s),   32'd5);
    endtask

    task automatic step(input logic [7:0] k);
        keycode = k;
        @(posedge frame_clk);
        model_step(k);
        #1;
        check_all("frame");
    endtask

    // Asserts reset mid-frame, holds it across one edge, releases mid-frame.
    task automatic do_reset();
        #3;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");
        @(posedge frame_clk);
        #1;
        check_all("reset_hold");
        #3;
        Reset_n = 1'b1;
    endtask

    initial begin
        int held;
        int frozen;
        logic [7:0] k;
        model_reset();

        // Reset and constant geometry.
        do_reset();
        for (int i = 0; i < NL; i++) check("lane_x", 32'(lane_x[10*i +: 10]), 32'(EXP_X[i]));

        // Idle scroll.
        repeat (10) step(8'h00);
        check("idle.fret_y", 32'(fret_y), 32'd10);
        check("idle.speed", 32'(speed), 32'd1);
        check("idle.paused", 32'(paused), 32'd0);
        check("idle.lane_hit", 32'(lane_hit), 32'd0);

        // Speed saturation both ways.
        repeat (9) begin step(K_FAST); step(8'h00); end
        check("speed_max", 32'(speed), 32'd7);
        repeat (8) begin step(K_SLOW); step(8'h00); end
        check("speed_min", 32'(speed), 32'd0);
        frozen = m_fret;
        repeat (3) step(8'h00);
        check("speed0_frozen", 32'(fret_y), 32'(frozen));

        // Wrap from 56 at speed 7.
        repeat (7) begin step(K_FAST); step(8'h00); end
        for (int n = 0; n < 120 && m_fret != 56; n++) step(8'h00);
        check("reach_56", 32'(fret_y), 32'd56);
        step(8'h00);
        check("wrap_56_to_3", 32'(fret_y), 32'd3);

        // Lane 1 held 3 frames, then 4 hold frames.
        for (int n = 1; n <= 9; n++) begin
            step((n <= 3) ? 8'h16 : 8'h00);
            check("lane1_hold", 32'(lane_hit), (n <= 7) ? 32'h2 : 32'h0);
        end

        // Pause held, then second press resumes.
        held = 0;
        for (int n = 1; n <= 5; n++) begin
            step(K_PAUSE);
            if (n == 1) held = m_fret;
            check("pause_held.paused", 32'(paused), 32'd1);
            check("pause_held.fret_y", 32'(fret_y), 32'(held));
        end
        repeat (2) step(8'h00);
        check("paused_fret", 32'(fret_y), 32'(held));
        step(K_PAUSE);
        check("unpause", 32'(paused), 32'd0);
        step(8'h00);
        check("resume_fret", 32'(fret_y), 32'((held + 7) % SPACING));

        // Reset mid-hold with pause active and pause key still held.
        repeat (2) step(8'h07);
        step(K_PAUSE);
        check("pre_reset_paused", 32'(paused), 32'd1);
        do_reset();
        step(K_PAUSE);
        check("post_reset_no_toggle", 32'(paused), 32'd0);
        check("post_reset_hit", 32'(lane_hit), 32'd0);
        check("post_reset_fret", 32'(fret_y), 32'd1);
        step(K_PAUSE);
        check("post_reset_still_run", 32'(paused), 32'd0);
        step(8'h00);
        step(K_PAUSE);
        check("post_reset_real_press", 32'(paused), 32'd1);

        // Randomized keycodes, occasional resets.
        k = 8'h00;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 11))
                    0:       k = k;
                    1, 2:    k = 8'h00;
                    3:       k = K_PAUSE;
                    4:       k = K_FAST;
                    5:       k = K_SLOW;
                    11:      k = 8'($urandom_range(0, 255));
                    default: k = LANE_KEY[$urandom_range(0, NL - 1)];
                endcase
                step(k);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
